// File: rtl/sle_cmp_scheduler_pkg.sv
// sle_cmp_scheduler_pkg: shared types and helpers for the SLE comparator scheduler
package sle_cmp_scheduler_pkg;
  localparam int MAX_W = 32;
  localparam int MAX_BUS = 16 * MAX_W;
  typedef struct packed {
    logic       le;
    logic [3:0] id;
  } resp_t;
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic logic [MAX_W-1:0] op_slice(input logic [MAX_BUS-1:0] bus, input int idx, input int w);
    return MAX_W'(bus >> (idx * w));
  endfunction
endpackage

// File: rtl/sle_cmp_scheduler_sle_cmp.sv
// sle_cmp: combinational signed less-or-equal compare, the shared resource
module sle_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             le_o
);
  assign le_o = $signed(a_i) <= $signed(b_i);
endmodule

// File: rtl/sle_cmp_scheduler.sv
// sle_cmp_scheduler: round-robin time-sharing of one signed <= comparator with a one-entry result stage
module sle_cmp_scheduler
  import sle_cmp_scheduler_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N_REQ = 4
) (
  input  logic                          CLK,
  input  logic                          ASYNCRESET,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*WIDTH-1:0]        req_a,
  input  logic [N_REQ*WIDTH-1:0]        req_b,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic                          resp_le,
  output logic [id_width(N_REQ)-1:0]    resp_id
);
  localparam int ID_W = id_width(N_REQ);
  logic [ID_W-1:0]  rr_q, rr_d, grant, idx;
  logic             hit, can_accept, accept, cmp_le, valid_q, valid_d;
  logic [WIDTH-1:0] op_a, op_b;
  resp_t            resp_q, resp_d;
  int               j;
  // priority search from rr_q; scanning offsets downward lets the smallest offset win
  always_comb begin
    grant = '0;
    hit = 1'b0;
    j = 0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(rr_q) + i;
      j = (j >= N_REQ) ? j - N_REQ : j;
      idx = ID_W'(j);
      if (req_valid[idx]) begin
        grant = idx;
        hit = 1'b1;
      end
    end
  end
  assign can_accept = !valid_q | resp_ready;
  assign accept     = hit & can_accept & !ASYNCRESET;
  assign req_ready  = accept ? (N_REQ'(1) << grant) : '0;
  assign op_a       = WIDTH'(op_slice(MAX_BUS'(req_a), int'(grant), WIDTH));
  assign op_b       = WIDTH'(op_slice(MAX_BUS'(req_b), int'(grant), WIDTH));
  sle_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a_i  (op_a),
    .b_i  (op_b),
    .le_o (cmp_le)
  );
  // a new result overwrites the stage on accept; a drain alone only clears valid
  always_comb begin
    valid_d = accept | (valid_q & !resp_ready);
    resp_d  = accept ? {cmp_le, 4'(grant)} : resp_q;
    rr_d    = accept ? ((grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1) : rr_q;
  end
  // output stage and round-robin pointer
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      valid_q <= 1'b0;
      resp_q  <= '0;
      rr_q    <= '0;
    end else begin
      valid_q <= valid_d;
      resp_q  <= resp_d;
      rr_q    <= rr_d;
    end
  end
  assign resp_valid = valid_q;
  assign resp_le    = resp_q.le;
  assign resp_id    = ID_W'(resp_q.id);
endmodule

// File: tb/tb_sle_cmp_scheduler.sv
// tb_sle_cmp_scheduler: scoreboard bench for the SLE comparator scheduler
module tb_sle_cmp_scheduler;
  localparam int W = 4;
  localparam int N = 4;
  localparam int ID_W = 2;
  logic            CLK = 1'b0;
  logic            ASYNCRESET = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*W-1:0]  req_a = '0;
  logic [N*W-1:0]  req_b = '0;
  logic [N-1:0]    req_ready;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic            resp_le;
  logic [ID_W-1:0] resp_id;
  int              errors = 0;
  int              checks = 0;
  logic [ID_W:0]   q[$];
  logic [ID_W:0]   seen[$];
  int              m_rr = 0;
  logic [N-1:0]    acc = '0;
  int              g;
  logic            can;
  logic [N-1:0]    er;

  always #5 CLK = ~CLK;

  sle_cmp_scheduler #(.WIDTH(W), .N_REQ(N)) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_le    (resp_le),
    .resp_id    (resp_id)
  );

  function automatic logic sle(input logic [W-1:0] a, input logic [W-1:0] b);
    return $signed(a) <= $signed(b);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_seen(input string tag, input int k, input logic [ID_W:0] exp);
    if (k < seen.size()) check(tag, 32'(seen[k]), 32'(exp));
    else check(tag, 32'hdead, 32'(exp));
  endtask

  // monitor: compare the held result, retire it on drain, predict the grant and push its result
  always @(negedge CLK) begin
    if (ASYNCRESET) begin
      check("rst_resp_valid", 32'(resp_valid), 32'(0));
      check("rst_req_ready", 32'(req_ready), 32'(0));
      acc = '0;
    end else begin
      check("resp_valid", 32'(resp_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check("resp_le", 32'(resp_le), 32'(q[0][ID_W]));
        check("resp_id", 32'(resp_id), 32'(q[0][ID_W-1:0]));
      end
      can = (q.size() == 0) || resp_ready;
      if (q.size() != 0 && resp_ready) seen.push_back(q.pop_front());
      g = -1;
      for (int k = N - 1; k >= 0; k--) if (req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
      er = '0;
      if (g >= 0 && can) er[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(er));
      acc = er;
      if (g >= 0 && can) begin
        q.push_back({sle(req_a[g*W +: W], req_b[g*W +: W]), ID_W'(g)});
        m_rr = (g + 1) % N;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic offer(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i] = 1'b1;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic drain();
    resp_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic do_reset();
    ASYNCRESET = 1'b1;
    req_valid = '1;
    q.delete();
    m_rr = 0;
    @(posedge CLK);
    #1;
    check("reset_resp_valid", 32'(resp_valid), 32'(0));
    check("reset_resp_le", 32'(resp_le), 32'(0));
    check("reset_resp_id", 32'(resp_id), 32'(0));
    check("reset_req_ready", 32'(req_ready), 32'(0));
    req_valid = '0;
    seen.delete();
    ASYNCRESET = 1'b0;
  endtask

  initial begin
    do_reset();
    resp_ready = 1'b1;
    offer(2, 4'b1000, 4'b0111);
    step();
    offer(1, 4'd3, 4'd3);
    step();
    offer(0, 4'd5, 4'd2);
    step();
    drain();
    check_seen("single_min_le_max", 0, 3'b110);
    check_seen("skip_to_1", 1, 3'b101);
    check_seen("wrap_to_0", 2, 3'b000);
    seen.delete();
    offer(0, 4'd7, 4'b1000);
    step();
    offer(0, 4'b1111, 4'b1111);
    step();
    offer(0, 4'd0, 4'b1111);
    step();
    drain();
    check_seen("cmp_7_le_m8", 0, 3'b000);
    check_seen("cmp_equal", 1, 3'b100);
    check_seen("cmp_0_le_m1", 2, 3'b000);
    do_reset();
    resp_ready = 1'b0;
    offer(0, 4'd1, 4'd2);
    step();
    offer(1, 4'b1110, 4'b1101);
    offer(3, 4'b1101, 4'b1110);
    repeat (3) step();
    resp_ready = 1'b1;
    step();
    step();
    drain();
    check_seen("bp_first", 0, 3'b100);
    check_seen("bp_then_1", 1, 3'b001);
    check_seen("bp_then_3", 2, 3'b111);
    do_reset();
    resp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) offer(i, W'(i), 4'd2);
      step();
    end
    req_valid = '0;
    drain();
    for (int k = 0; k < 8; k++) check_seen($sformatf("fair_%0d", k), k, {((k % 4) != 3), ID_W'(k % 4)});
    seen.delete();
    resp_ready = 1'b0;
    offer(1, 4'd2, 4'd1);
    step();
    step();
    @(negedge CLK);
    #2;
    ASYNCRESET = 1'b1;
    #1;
    check("async_drop_valid", 32'(resp_valid), 32'(0));
    check("async_ready_low", 32'(req_ready), 32'(0));
    q.delete();
    m_rr = 0;
    req_valid = '0;
    @(posedge CLK);
    #1;
    ASYNCRESET = 1'b0;
    seen.delete();
    offer(0, 4'd4, 4'd4);
    offer(2, 4'd6, 4'd1);
    resp_ready = 1'b1;
    step();
    step();
    drain();
    check_seen("post_reset_first_0", 0, 3'b100);
    check_seen("post_reset_then_2", 1, 3'b010);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
